// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types, register map and status bit indices for the PS/2 host transmitter
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_START,
      ST_TX,
      ST_ACK,
      ST_WAITREL
   } ps2_state_e;

   // Register offsets as decoded from wb_adr_i[3:2]
   localparam logic [1:0] REG_TXDATA = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;

   // STATUS bit indices
   localparam int BIT_BUSY = 0;
   localparam int BIT_DONE = 1;
   localparam int BIT_NACK = 2;
   localparam int BIT_TMO  = 3;
   localparam int BIT_OVR  = 4;

   // PS/2 frames carry odd parity over the data byte
   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - 2-flop synchronizers for PS2_CLK/PS2_DATA and PS2_CLK falling-edge detect
module ps2_line_sync (
   input  logic clk,
   input  logic rst_i,
   input  logic ps2_clk_i,
   input  logic ps2_data_i,
   output logic clk_s_o,
   output logic data_s_o,
   output logic clk_fall_o
);

   logic [1:0] clk_sync_q;
   logic [1:0] data_sync_q;
   logic       clk_prev_q;

   // Synchronize both pins; idle bus level is high, so reset to 1 to avoid a false edge
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         clk_sync_q  <= 2'b11;
         data_sync_q <= 2'b11;
         clk_prev_q  <= 1'b1;
      end else begin
         clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
         data_sync_q <= {data_sync_q[0], ps2_data_i};
         clk_prev_q  <= clk_sync_q[1];
      end
   end

   assign clk_s_o    = clk_sync_q[1];
   assign data_s_o   = data_sync_q[1];
   assign clk_fall_o = clk_prev_q & ~clk_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - Wishbone PS/2 host-to-device command transmitter (optional IRQ via PS2_TX_IRQ_EN)
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        wb_rst_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   input  logic [3:0]  wb_sel_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        wb_err_o,
   input  logic        ps2_clk_i,
   input  logic        ps2_data_i,
   output logic        ps2_clk_oe,
   output logic        ps2_data_oe
`ifdef PS2_TX_IRQ_EN
   ,
   output logic        irq
`endif
);

   localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

   ps2_state_e  state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  byte_q, byte_d;
   logic        clk_oe_q, clk_oe_d;
   logic        data_oe_q, data_oe_d;
   logic        done_q, nack_q, tmo_q, ovr_q;
   logic        ack_q, err_q;
   logic        set_done, set_nack, set_tmo;
   logic        clk_s, data_s, clk_fall;
   logic        req, addr_ok, wr, tx_wr, st_wr;
   logic [1:0]  addr;
   logic [31:0] rdata;
   logic        unused_bits;

   ps2_line_sync u_sync (
      .clk        (clk),
      .rst_i      (wb_rst_i),
      .ps2_clk_i  (ps2_clk_i),
      .ps2_data_i (ps2_data_i),
      .clk_s_o    (clk_s),
      .data_s_o   (data_s),
      .clk_fall_o (clk_fall)
   );

   assign req   = wb_cyc_i & wb_stb_i;
   assign addr  = wb_adr_i[3:2];
   assign wr    = ack_q & req & wb_we_i & wb_sel_i[0];
   assign tx_wr = wr & (addr == REG_TXDATA);
   assign st_wr = wr & (addr == REG_STATUS);

`ifdef PS2_TX_IRQ_EN
   logic irq_en_q, irq_q;
   assign addr_ok = (addr == REG_TXDATA) | (addr == REG_STATUS) | (addr == REG_CTRL);
`else
   assign addr_ok = (addr == REG_TXDATA) | (addr == REG_STATUS);
`endif

   // Frame sequencer: next state, line drive and status set pulses
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_cnt_d = bit_cnt_q;
      byte_d    = byte_q;
      clk_oe_d  = 1'b0;
      data_oe_d = data_oe_q;
      set_done  = 1'b0;
      set_nack  = 1'b0;
      set_tmo   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            data_oe_d = 1'b0;
            if (tx_wr) begin
               state_d  = ST_INHIBIT;
               byte_d   = wb_dat_i[7:0];
               cnt_d    = '0;
               clk_oe_d = 1'b1;
            end
         end
         ST_INHIBIT: begin
            clk_oe_d  = 1'b1;
            data_oe_d = 1'b0;
            if (cnt_q == INH_LAST) begin
               state_d   = ST_START;
               data_oe_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_START: begin
            // Start bit stays low until the device's first falling edge
            state_d   = ST_TX;
            data_oe_d = 1'b1;
            cnt_d     = '0;
            bit_cnt_d = '0;
         end
         ST_TX: begin
            if (cnt_q == TMO_LAST) begin
               state_d   = ST_IDLE;
               data_oe_d = 1'b0;
               set_tmo   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (clk_fall) begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q < 4'd8) begin
                     data_oe_d = ~byte_q[bit_cnt_q[2:0]];
                  end else if (bit_cnt_q == 4'd8) begin
                     data_oe_d = ~odd_parity(byte_q);
                  end else begin
                     data_oe_d = 1'b0;
                     state_d   = ST_ACK;
                  end
               end
            end
         end
         ST_ACK: begin
            data_oe_d = 1'b0;
            if (cnt_q == TMO_LAST) begin
               state_d = ST_IDLE;
               set_tmo = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (clk_fall) begin
                  set_done = 1'b1;
                  set_nack = data_s;
                  state_d  = ST_WAITREL;
               end
            end
         end
         ST_WAITREL: begin
            data_oe_d = 1'b0;
            if (clk_s & data_s) state_d = ST_IDLE;
         end
         default: begin
            state_d   = ST_IDLE;
            data_oe_d = 1'b0;
         end
      endcase
   end

   // Sequencer state and registered open-drain enables
   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bit_cnt_q <= '0;
         byte_q    <= '0;
         clk_oe_q  <= 1'b0;
         data_oe_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_cnt_q <= bit_cnt_d;
         byte_q    <= byte_d;
         clk_oe_q  <= clk_oe_d;
         data_oe_q <= data_oe_d;
      end
   end

   // Sticky status flags; a set in the same cycle as a W1C clear wins
   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         done_q <= 1'b0;
         nack_q <= 1'b0;
         tmo_q  <= 1'b0;
         ovr_q  <= 1'b0;
      end else begin
         done_q <= (done_q & ~(st_wr & wb_dat_i[BIT_DONE])) | set_done;
         nack_q <= (nack_q & ~(st_wr & wb_dat_i[BIT_NACK])) | set_nack;
         tmo_q  <= (tmo_q  & ~(st_wr & wb_dat_i[BIT_TMO]))  | set_tmo;
         ovr_q  <= (ovr_q  & ~(st_wr & wb_dat_i[BIT_OVR]))  | (tx_wr & (state_q != ST_IDLE));
      end
   end

   // Single-cycle ack/err, never back to back
   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         ack_q <= req & ~ack_q & ~err_q & addr_ok;
         err_q <= req & ~ack_q & ~err_q & ~addr_ok;
      end
   end

`ifdef PS2_TX_IRQ_EN
   // Interrupt enable register and registered interrupt output
   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         if (wr & (addr == REG_CTRL)) irq_en_q <= wb_dat_i[0];
         irq_q <= irq_en_q & (done_q | tmo_q);
      end
   end
   assign irq = irq_q;
`endif

   // Read data mux; TXDATA and unmapped offsets read as zero
   always_comb begin
      rdata = '0;
      if (addr == REG_STATUS) begin
         rdata[BIT_BUSY] = (state_q != ST_IDLE);
         rdata[BIT_DONE] = done_q;
         rdata[BIT_NACK] = nack_q;
         rdata[BIT_TMO]  = tmo_q;
         rdata[BIT_OVR]  = ovr_q;
      end
`ifdef PS2_TX_IRQ_EN
      if (addr == REG_CTRL) rdata[0] = irq_en_q;
`endif
   end

   assign wb_dat_o    = req ? rdata : 32'd0;
   assign wb_ack_o    = ack_q;
   assign wb_err_o    = err_q;
   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;

   assign unused_bits = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:8], wb_sel_i[3:1]};

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed self-checking bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;

   localparam int INH  = 20;
   localparam int TMO  = 2000;
   localparam int HALF = 8;

   logic        clk = 1'b0;
   logic        wb_rst_i = 1'b1;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [31:0] adr = '0, dat_i = '0;
   logic [3:0]  sel = '0;
   logic [31:0] dat_o;
   logic        ack, err;
   logic        dev_clk = 1'b1, dev_data = 1'b1;
   logic        clk_oe, data_oe;
   logic        line_clk, line_data;
   int          n_cmp = 0;
   int          n_bad = 0;

   // Open-drain bus: either side may pull a line low
   assign line_clk  = dev_clk & ~clk_oe;
   assign line_data = dev_data & ~data_oe;

   always #5 clk = ~clk;

`ifdef PS2_TX_IRQ_EN
   logic irq;
`endif

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
      .clk         (clk),
      .wb_rst_i    (wb_rst_i),
      .wb_cyc_i    (cyc),
      .wb_stb_i    (stb),
      .wb_we_i     (we),
      .wb_adr_i    (adr),
      .wb_dat_i    (dat_i),
      .wb_sel_i    (sel),
      .wb_dat_o    (dat_o),
      .wb_ack_o    (ack),
      .wb_err_o    (err),
      .ps2_clk_i   (line_clk),
      .ps2_data_i  (line_data),
      .ps2_clk_oe  (clk_oe),
      .ps2_data_oe (data_oe)
`ifdef PS2_TX_IRQ_EN
      ,
      .irq         (irq)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc_wait(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic got_ack, output logic got_err);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = 4'hF;
      rd = '0; got_ack = 1'b0; got_err = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (ack || err) begin
            rd = dat_o; got_ack = ack; got_err = err;
            break;
         end
      end
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input string tag);
      logic [31:0] rd;
      logic ga, ge;
      wb_xfer(1'b1, a, d, rd, ga, ge);
      chk({tag, " ack"}, {31'd0, ga}, 32'd1);
   endtask

   task automatic wb_read_chk(input logic [31:0] a, input logic [31:0] exp, input string tag);
      logic [31:0] rd;
      logic ga, ge;
      wb_xfer(1'b0, a, 32'd0, rd, ga, ge);
      chk({tag, " ack"}, {31'd0, ga}, 32'd1);
      chk(tag, rd, exp);
   endtask

   // Device side: clock out ten bits, capture line levels, then ACK (or abort with reset)
   task automatic device_frame(input logic ack_bit, input int ovr_at, input int rst_at,
                               input logic [9:0] exp_bits, input string tag);
      logic [9:0] cap;
      int w;
      cap = '0;
      w = 0;
      while (clk_oe !== 1'b0 && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk({tag, " clk release"}, {31'd0, clk_oe}, 32'd0);
      chk({tag, " start bit"}, {31'd0, data_oe}, 32'd1);
      cyc_wait(2);
      for (int k = 1; k <= 10; k++) begin
         dev_clk = 1'b0;
         cyc_wait(HALF);
         if (k == rst_at) begin
            chk({tag, " pre-reset data_oe"}, {31'd0, data_oe}, 32'd1);
            #2 wb_rst_i = 1'b1;
            #1 chk({tag, " reset oe"}, {30'd0, clk_oe, data_oe}, 32'd0);
            cyc_wait(1);
            wb_rst_i = 1'b0;
            dev_clk  = 1'b1;
            cyc_wait(HALF);
            return;
         end
         @(negedge clk);
         cap[k-1] = line_data;
         cyc_wait(1);
         dev_clk = 1'b1;
         cyc_wait(HALF);
         if (k == ovr_at) wb_write(32'h0, 32'h55, {tag, " ovr write"});
      end
      chk({tag, " bits"}, {22'd0, cap}, {22'd0, exp_bits});
      dev_data = ack_bit;
      cyc_wait(2);
      dev_clk = 1'b0;
      cyc_wait(HALF);
      dev_clk  = 1'b1;
      dev_data = 1'b1;
      cyc_wait(HALF);
   endtask

   initial begin
      int c;
      logic [31:0] rd;
      logic ga, ge;

      // Reset values
      cyc_wait(3);
      @(negedge clk);
      chk("reset oe", {30'd0, clk_oe, data_oe}, 32'd0);
      chk("reset ack/err", {30'd0, ack, err}, 32'd0);
      chk("reset dat_o", dat_o, 32'd0);
      cyc_wait(1);
      wb_rst_i = 1'b0;
      cyc_wait(2);
      wb_read_chk(32'h4, 32'h00, "reset status");
      wb_read_chk(32'h0, 32'h00, "txdata read");

      // 0xED with ACK 0; inhibit length and start cycle
      wb_write(32'h0, 32'hED, "ed write");
      c = 0;
      @(negedge clk);
      while (clk_oe === 1'b1 && data_oe === 1'b0 && c < 100) begin
         c++;
         @(negedge clk);
      end
      chk("inhibit cycles", c, INH);
      chk("start oe", {30'd0, clk_oe, data_oe}, 32'd3);
      device_frame(1'b0, 0, 0, 10'h3ED, "ed");
      cyc_wait(4);
      wb_read_chk(32'h4, 32'h02, "ed status");
      wb_write(32'h4, 32'h1F, "clr1");
      wb_read_chk(32'h4, 32'h00, "clr1 status");

      // 0x00 with NACK
      wb_write(32'h0, 32'h00, "00 write");
      device_frame(1'b1, 0, 0, 10'h300, "00");
      cyc_wait(4);
      wb_read_chk(32'h4, 32'h06, "00 status");
      wb_write(32'h4, 32'h1F, "clr2");

      // 0xFF with silent device: timeout
      wb_write(32'h0, 32'hFF, "ff write");
      c = 0;
      while (clk_oe !== 1'b0 && c < 100) begin
         @(negedge clk);
         c++;
      end
      chk("ff clk release", {31'd0, clk_oe}, 32'd0);
      chk("ff start bit", {31'd0, data_oe}, 32'd1);
      c = 0;
      while (data_oe === 1'b1 && c < 3000) begin
         @(negedge clk);
         c++;
      end
      chk("timeout cycles", c, TMO);
      chk("timeout oe", {30'd0, clk_oe, data_oe}, 32'd0);
      cyc_wait(2);
      wb_read_chk(32'h4, 32'h08, "ff status");
      wb_write(32'h4, 32'h1F, "clr3");

      // 0xF3 with a second write mid-frame
      wb_write(32'h0, 32'hF3, "f3 write");
      device_frame(1'b0, 3, 0, 10'h3F3, "f3");
      cyc_wait(4);
      wb_read_chk(32'h4, 32'h12, "f3 status");
      wb_write(32'h4, 32'h1F, "clr4");

      // Reset during bit 4, then a clean frame
      wb_write(32'h0, 32'hF3, "rst write");
      device_frame(1'b0, 0, 4, 10'h000, "rst");
      wb_read_chk(32'h4, 32'h00, "post-reset status");
      wb_write(32'h0, 32'hED, "ed2 write");
      device_frame(1'b0, 0, 0, 10'h3ED, "ed2");
      cyc_wait(4);
      wb_read_chk(32'h4, 32'h02, "ed2 status");

      // Unmapped offset and W1C of done
      wb_xfer(1'b0, 32'hC, 32'd0, rd, ga, ge);
      chk("0xC err", {31'd0, ge}, 32'd1);
      chk("0xC ack", {31'd0, ga}, 32'd0);
      @(negedge clk);
      chk("0xC err single", {30'd0, ack, err}, 32'd0);
      cyc_wait(1);
      wb_write(32'h4, 32'h02, "w1c done");
      wb_read_chk(32'h4, 32'h00, "w1c status");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
